// File: rtl/spi_register_controller.sv
// Byte-level SPI register controller: an opcode byte selects one of four register ports, and the
// payload bytes that follow are forwarded to that port. SPI_REGISTER_TIMEOUT_EN adds a watchdog.
module spi_register_controller #(
    parameter logic [7:0]  ADDR_0         = 8'hB5,
    parameter logic [7:0]  ADDR_1         = 8'hB6,
    parameter logic [7:0]  ADDR_2         = 8'hB7,
    parameter logic [7:0]  ADDR_3         = 8'hB8,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        i_system_clock,
    input  logic        i_reset_n,
    input  logic        i_cs_active,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_in_valid,
    output logic [7:0]  o_byte_out,
    output logic [3:0]  o_reg_enable,
    output logic [7:0]  o_reg_data_in,
    output logic        o_reg_data_in_valid,
    input  logic [31:0] i_reg_data_out,
    input  logic [3:0]  i_reg_data_out_valid,
    output logic [7:0]  o_byte_count,
    output logic        o_unknown_address,
    output logic        o_timeout
);

    typedef enum logic [1:0] {StIdle, StOpcode, StActive, StDrain} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [1:0] r_sel;
    logic [1:0] w_sel_next;
    logic       w_match;
    logic [1:0] w_match_idx;
    logic       w_wd_expire;
    logic       w_byte_accept;

    logic [7:0] w_byte_out_next;
    logic [3:0] w_reg_enable_next;
    logic [7:0] w_reg_data_in_next;
    logic       w_reg_data_in_valid_next;
    logic [7:0] w_byte_count_next;
    logic       w_unknown_next;
    logic       w_timeout_next;

    // Priority order resolves colliding opcode parameters to the lowest port.
    always_comb begin
        w_match     = 1'b1;
        w_match_idx = 2'd0;
        if (i_byte_in == ADDR_0) begin
            w_match_idx = 2'd0;
        end else if (i_byte_in == ADDR_1) begin
            w_match_idx = 2'd1;
        end else if (i_byte_in == ADDR_2) begin
            w_match_idx = 2'd2;
        end else if (i_byte_in == ADDR_3) begin
            w_match_idx = 2'd3;
        end else begin
            w_match = 1'b0;
        end
    end

`ifdef SPI_REGISTER_TIMEOUT_EN
    logic [15:0] r_wd_count;
    logic        w_wd_armed;

    assign w_wd_armed  = ((r_state == StOpcode) || (r_state == StActive)) && i_cs_active
                         && !i_byte_in_valid;
    assign w_wd_expire = w_wd_armed && (r_wd_count == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge i_system_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wd_count <= 16'd0;
        end else if (!w_wd_armed || w_wd_expire) begin
            r_wd_count <= 16'd0;
        end else begin
            r_wd_count <= r_wd_count + 16'd1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_wd_expire      = 1'b0;
`endif

    always_ff @(posedge i_system_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
        end
    end

    // Dropping chip select takes priority over any byte arriving in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        unique case (r_state)
            StIdle: begin
                if (i_cs_active) w_state_next = StOpcode;
            end
            StOpcode: begin
                if (!i_cs_active) begin
                    w_state_next = StIdle;
                end else if (w_wd_expire) begin
                    w_state_next = StDrain;
                end else if (i_byte_in_valid) begin
                    if (w_match) begin
                        w_state_next = StActive;
                        w_sel_next   = w_match_idx;
                    end else begin
                        w_state_next = StDrain;
                    end
                end
            end
            StActive: begin
                if (!i_cs_active) begin
                    w_state_next = StIdle;
                end else if (w_wd_expire) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (!i_cs_active) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_byte_accept = (r_state == StActive) && i_cs_active && i_byte_in_valid;

    always_comb begin
        w_reg_enable_next        = 4'h0;
        w_byte_out_next          = 8'h00;
        w_reg_data_in_next       = o_reg_data_in;
        w_reg_data_in_valid_next = 1'b0;
        w_byte_count_next        = o_byte_count;
        w_unknown_next           = 1'b0;
        w_timeout_next           = w_wd_expire;

        if (w_state_next == StActive) begin
            w_reg_enable_next = 4'b0001 << w_sel_next;
            if (i_reg_data_out_valid[w_sel_next]) begin
                w_byte_out_next = i_reg_data_out[{w_sel_next, 3'b000} +: 8];
            end
        end

        if (w_byte_accept) begin
            w_reg_data_in_next       = i_byte_in;
            w_reg_data_in_valid_next = 1'b1;
            if (o_byte_count != 8'hFF) w_byte_count_next = o_byte_count + 8'd1;
        end

        if (w_state_next == StIdle) w_byte_count_next = 8'h00;

        if ((r_state == StOpcode) && i_cs_active && i_byte_in_valid && !w_match) begin
            w_unknown_next = 1'b1;
        end
    end

    always_ff @(posedge i_system_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_byte_out          <= 8'h00;
            o_reg_enable        <= 4'h0;
            o_reg_data_in       <= 8'h00;
            o_reg_data_in_valid <= 1'b0;
            o_byte_count        <= 8'h00;
            o_unknown_address   <= 1'b0;
            o_timeout           <= 1'b0;
        end else begin
            o_byte_out          <= w_byte_out_next;
            o_reg_enable        <= w_reg_enable_next;
            o_reg_data_in       <= w_reg_data_in_next;
            o_reg_data_in_valid <= w_reg_data_in_valid_next;
            o_byte_count        <= w_byte_count_next;
            o_unknown_address   <= w_unknown_next;
            o_timeout           <= w_timeout_next;
        end
    end

endmodule

// File: doc/spi_register_controller.md
SPI_REGISTER_CONTROLLER -- requirements
Module: spi_register_controller

Interface
REQ-001 SHALL have parameter ADDR_0, default 8'hB5, opcode selecting register port 0.
REQ-002 SHALL have parameter ADDR_1, default 8'hB6, opcode selecting register port 1.
REQ-003 SHALL have parameter ADDR_2, default 8'hB7, opcode selecting register port 2.
REQ-004 SHALL have parameter ADDR_3, default 8'hB8, opcode selecting register port 3.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16'd50000, idle-byte watchdog limit; used only with SPI_REGISTER_TIMEOUT_EN.
REQ-006 system_clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 cs_active  input  1  SPI transaction in progress, already synchronous to system_clock.
REQ-009 byte_in  input  8  byte received from SPI peripheral.
REQ-010 byte_in_valid  input  1  one-cycle strobe qualifying byte_in.
REQ-011 byte_out  output  8  byte to shift out on next SPI byte.
REQ-012 reg_enable  output  4  one-hot enable to selected register block.
REQ-013 reg_data_in  output  8  payload byte forwarded to selected block.
REQ-014 reg_data_in_valid  output  1  one-cycle strobe qualifying reg_data_in.
REQ-015 reg_data_out  input  32  packed port data, port n at bits [8n+7:8n].
REQ-016 reg_data_out_valid  input  4  per-port data valid.
REQ-017 byte_count  output  8  payload bytes in current transaction, saturating.
REQ-018 unknown_address  output  1  one-cycle pulse on unmatched opcode.
REQ-019 timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-020 FSM states SHALL be IDLE, OPCODE, ACTIVE, DRAIN.
REQ-021 IDLE -> OPCODE on cycle cs_active is sampled high.
REQ-022 OPCODE, byte_in_valid with byte_in matching ADDR_n -> ACTIVE; reg_enable bit n set on next edge.
REQ-023 OPCODE, byte_in_valid with no match -> DRAIN; unknown_address pulses exactly one cycle; reg_enable stays 0.
REQ-024 Matching SHALL use lowest port index if parameters collide.
REQ-025 ACTIVE, each byte_in_valid -> reg_data_in = byte_in and reg_data_in_valid high, both registered, latency 1 cycle.
REQ-026 ACTIVE, each byte_in_valid increments byte_count by 1, saturating at 8'hFF; opcode byte not counted.
REQ-027 byte_out SHALL be registered: selected port's byte when its reg_data_out_valid is 1, else 8'h00; 8'h00 in IDLE, OPCODE, DRAIN.
REQ-028 DRAIN ignores all bytes until cs_active low.
REQ-029 cs_active low in any non-IDLE state -> IDLE next edge; reg_enable, reg_data_in_valid, byte_count cleared there.
REQ-030 cs_active low coincident with byte_in_valid: drop wins, byte discarded, no reg_data_in_valid.
REQ-031 cs_active low-to-high within one cycle of returning to IDLE SHALL start a fresh transaction normally.
REQ-032 reg_enable SHALL never have more than one bit set.

Reset
REQ-033 reset_n low SHALL asynchronously force state IDLE, byte_out 8'h00, reg_enable 4'h0, reg_data_in 8'h00, reg_data_in_valid 0, byte_count 8'h00, unknown_address 0, timeout 0, watchdog counter 0.
REQ-034 Reset asserted mid-transaction SHALL abort it; after release, block waits in IDLE until cs_active sampled high again.

Configuration
REQ-035 With SPI_REGISTER_TIMEOUT_EN defined: 16-bit watchdog counts cycles in OPCODE/ACTIVE without byte_in_valid, clears on each byte_in_valid; reaching TIMEOUT_CYCLES -> DRAIN, reg_enable cleared, timeout pulses one cycle.
REQ-036 Without SPI_REGISTER_TIMEOUT_EN: no watchdog logic, timeout tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-037 cs high, byte 8'hB5, then 4 bytes with reg_data_out_valid[0]=1, port0 data "T","e","s","t" -> reg_enable=4'b0001, 4 reg_data_in_valid pulses, byte_out follows port0 data, byte_count=4.
REQ-038 cs high, byte 8'h42, then 3 bytes -> unknown_address one pulse, reg_enable=0, no reg_data_in_valid, byte_out 8'h00 throughout.
REQ-039 300 payload bytes to port 2 (8'hB7) -> byte_count saturates at 8'hFF; cs low -> byte_count 0, reg_enable 0 next cycle.
REQ-040 cs low same cycle as third payload byte -> only 2 reg_data_in_valid pulses, state IDLE next cycle.
REQ-041 reset_n low during ACTIVE on port 3 -> all outputs at reset values immediately, no activity until next cs rise.
REQ-042 With SPI_REGISTER_TIMEOUT_EN, TIMEOUT_CYCLES=100, opcode 8'hB6 then no bytes -> timeout pulses at cycle 100, reg_enable cleared, later bytes ignored until cs low.
